// File: rtl/siso_frame_sched_if.sv
// Parallel-in handshake and serial-out strobes of the frame scheduler.
// The producer/monitor side takes the master modport; the scheduler takes the slave modport.
interface siso_frame_sched_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [1:0]       in_ready;
  logic             so;
  logic             so_valid;
  logic             so_first;
  logic             so_last;
  logic             so_src;
  logic             busy;

  modport master (
    output in_valid, in_data0, in_data1,
    input  in_ready, so, so_valid, so_first, so_last, so_src, busy
  );

  modport slave (
    input  in_valid, in_data0, in_data1,
    output in_ready, so, so_valid, so_first, so_last, so_src, busy
  );
endinterface

// File: rtl/siso_frame_sched.sv
// Round-robin two-requester scheduler feeding a WIDTH-bit MSB-first shift register,
// with first/last framing strobes and GAP idle cycles after every frame.
module siso_frame_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  siso_frame_sched_if.slave  bus
);

  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_TOP = CW'(WIDTH - 1);
  localparam logic [3:0]      GAP_TOP = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [3:0]       r_gap_cnt;
  logic             r_last_grant;
  logic             r_src;

  logic [1:0]       w_ready;
  logic             w_prio;
  logic             w_xfer;
  logic             w_sel;
  logic             w_shift;

  // Priority goes to whichever requester was not granted last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_ready = 2'b00;
    w_prio  = ~r_last_grant;
    if (r_state == ST_IDLE) begin
      if (bus.in_valid[w_prio]) begin
        w_ready[w_prio] = 1'b1;
      end else if (bus.in_valid[~w_prio]) begin
        w_ready[~w_prio] = 1'b1;
      end
    end
  end

  assign w_xfer  = |w_ready;
  assign w_sel   = w_ready[1];
  assign w_shift = (r_state == ST_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == '0) w_state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= 4'd0;
      r_last_grant <= 1'b1;
      r_src        <= 1'b0;
    end else if (w_xfer) begin
      r_shreg      <= w_sel ? bus.in_data1 : bus.in_data0;
      r_bit_cnt    <= CNT_TOP;
      r_src        <= w_sel;
      r_last_grant <= w_sel;
    end else if (w_shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      if (r_bit_cnt != '0) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end else begin
        r_gap_cnt <= GAP_TOP;
      end
    end else if (r_state == ST_GAP) begin
      if (r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // Serial strobes are gated by SHIFT so they read zero outside a frame.
  assign bus.in_ready = w_ready;
  assign bus.so       = w_shift & r_shreg[WIDTH-1];
  assign bus.so_valid = w_shift;
  assign bus.so_first = w_shift && (r_bit_cnt == CNT_TOP);
  assign bus.so_last  = w_shift && (r_bit_cnt == '0);
  assign bus.so_src   = r_src;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule
